// File: rtl/button_debouncer.sv
// Mechanical-switch debouncer: synchronizer, four-state qualification FSM,
// registered level with rise/fall strobes and a saturating glitch counter.
module button_debouncer #(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_btn,
  output logic                o_level,
  output logic                o_rise,
  output logic                o_fall,
  output logic [GLITCH_W-1:0] o_glitch_cnt
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  // The entering cycle already counts as 1, so qualification completes when
  // the stored count equals STABLE_CYCLES-1 and s still holds the new value.
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d;
  logic             rise_d;
  logic             fall_d;
  logic             glitch_inc;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_btn};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;

    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end

      WAIT_HIGH: begin
        if (!s) begin
          state_d    = IDLE_LOW;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end

      WAIT_LOW: begin
        if (s) begin
          state_d    = IDLE_HIGH;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase

    // The level is decoded from the next state so it registers alongside it.
    level_d = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE_LOW;
      cnt_q        <= '0;
      o_level      <= 1'b0;
      o_rise       <= 1'b0;
      o_fall       <= 1'b0;
      o_glitch_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_level <= level_d;
      o_rise  <= rise_d;
      o_fall  <= fall_d;
      if (glitch_inc && (o_glitch_cnt != '1)) begin
        o_glitch_cnt <= o_glitch_cnt + GLITCH_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios with literal
// expectations plus random bounce stress against a run-length reference model.
module tb_button_debouncer;

  localparam int STABLE = 4;
  localparam int SYNC   = 2;
  localparam int GW     = 3;
  localparam int GMAX   = (1 << GW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_btn = 1'b0;
  logic          o_level;
  logic          o_rise;
  logic          o_fall;
  logic [GW-1:0] o_glitch_cnt;

  button_debouncer #(
    .STABLE_CYCLES(STABLE),
    .SYNC_STAGES  (SYNC),
    .GLITCH_W     (GW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_btn       (i_btn),
    .o_level     (o_level),
    .o_rise      (o_rise),
    .o_fall      (o_fall),
    .o_glitch_cnt(o_glitch_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rise_cnt, fall_cnt, last_rise_cyc, last_fall_cyc;

  // Reference model: s is the input delayed SYNC edges; the level flips once
  // s has disagreed with it for STABLE consecutive cycles, and any run that
  // ends early is one glitch.
  bit m_sync [SYNC];
  bit m_level, m_rise, m_fall;
  int m_run, m_glitch;

  bit pat_bounce [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  bit pat_release [3] = '{1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input bit b, input bit r);
    bit s;
    if (r) begin
      for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
      m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
      m_run = 0; m_glitch = 0;
    end else begin
      s = m_sync[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = b;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_level) begin
        m_run++;
        if (m_run == STABLE) begin
          m_level = s;
          m_rise  = s;
          m_fall  = !s;
          m_run   = 0;
        end
      end else if (m_run > 0) begin
        m_run = 0;
        if (m_glitch < GMAX) m_glitch++;
      end
    end
  endtask

  task automatic compare_outputs();
    n_cmp++;
    if ($isunknown({o_level, o_rise, o_fall, o_glitch_cnt}) ||
        o_level !== m_level || o_rise !== m_rise || o_fall !== m_fall ||
        o_glitch_cnt !== GW'(m_glitch)) begin
      n_fail++;
      $display("FAIL model_cmp cycle %0d: got level=%b rise=%b fall=%b glitch=%0d, expected level=%b rise=%b fall=%b glitch=%0d",
               cyc, o_level, o_rise, o_fall, o_glitch_cnt, m_level, m_rise, m_fall, m_glitch);
    end
  endtask

  // One clock: drive during the low phase, let the edge happen, then compare.
  task automatic tick(input bit b, input bit r);
    @(negedge clk);
    i_btn = b;
    rst   = r;
    @(posedge clk);
    model_step(b, r);
    #1;
    if (r) cyc = 0;
    else   cyc++;
    compare_outputs();
    if (o_rise === 1'b1) begin rise_cnt++; last_rise_cyc = cyc; end
    if (o_fall === 1'b1) begin fall_cnt++; last_fall_cyc = cyc; end
  endtask

  task automatic clear_tallies();
    rise_cnt = 0; fall_cnt = 0; last_rise_cyc = -1; last_fall_cyc = -1;
  endtask

  initial begin
    int base;
    bit cur;
    int len;
    int done;
    bit early_drop;

    // Reset state
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("rst_level",  32'(o_level), 32'd0);
    check("rst_rise",   32'(o_rise),  32'd0);
    check("rst_fall",   32'(o_fall),  32'd0);
    check("rst_glitch", 32'(o_glitch_cnt), 32'd0);

    // 1. Clean press at cycle 10, level and rise at cycle 16
    clear_tallies();
    for (int c = 0; c < 16; c++) begin
      tick(c >= 10, 1'b0);
      if (cyc == 15) check("t1_level_before", 32'(o_level), 32'd0);
    end
    check("t1_level",     32'(o_level), 32'd1);
    check("t1_rise",      32'(o_rise),  32'd1);
    check("t1_rise_cyc",  32'(last_rise_cyc), 32'd16);
    check("t1_glitch",    32'(o_glitch_cnt), 32'd0);
    tick(1'b1, 1'b0);
    check("t1_rise_drop", 32'(o_rise),  32'd0);
    check("t1_level_hold", 32'(o_level), 32'd1);
    check("t1_no_fall",   32'(fall_cnt), 32'd0);

    // 2. Bounce: 111 0 11 0 1..., one rise 4 cycles after the last 0->1 at s
    tick(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    clear_tallies();
    base = cyc;
    for (int i = 0; i < 8; i++) tick(pat_bounce[i], 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    check("t2_rise_cnt", 32'(rise_cnt), 32'd1);
    check("t2_rise_cyc", 32'(last_rise_cyc), 32'(base + 13));
    check("t2_glitch",   32'(o_glitch_cnt), 32'd2);
    check("t2_level",    32'(o_level), 32'd1);

    // 3. Release with a one-cycle glitch: level holds, then one fall
    clear_tallies();
    early_drop = 1'b0;
    base = cyc;
    for (int i = 0; i < 13; i++) begin
      tick((i < 3) ? pat_release[i] : 1'b0, 1'b0);
      if (cyc < base + 9 && o_level !== 1'b1) early_drop = 1'b1;
    end
    check("t3_level_hold", 32'(early_drop), 32'd0);
    check("t3_fall_cnt",   32'(fall_cnt), 32'd1);
    check("t3_fall_cyc",   32'(last_fall_cyc), 32'(base + 9));
    check("t3_glitch",     32'(o_glitch_cnt), 32'd3);
    check("t3_level",      32'(o_level), 32'd0);

    // 4. Saturation: ten 2-cycle glitches, count stops at 7
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int g = 1; g <= 10; g++) begin
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
      check("t4_glitch", 32'(o_glitch_cnt), 32'((g < 7) ? g : 7));
      check("t4_level",  32'(o_level), 32'd0);
    end

    // 5. Reset in WAIT_HIGH at count 3, input held high through it
    tick(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check("t5_level",  32'(o_level), 32'd0);
    check("t5_rise",   32'(o_rise),  32'd0);
    check("t5_fall",   32'(o_fall),  32'd0);
    check("t5_glitch", 32'(o_glitch_cnt), 32'd0);
    clear_tallies();
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    check("t5_rise_cnt", 32'(rise_cnt), 32'd1);
    check("t5_rise_cyc", 32'(last_rise_cyc), 32'd6);

    // 6. Random stress: run lengths 1..8 over 5000 cycles
    tick(1'b0, 1'b1);
    clear_tallies();
    done = 0;
    cur  = 1'b0;
    while (done < 5000) begin
      cur = ~cur;
      len = int'($urandom_range(8, 1));
      for (int i = 0; i < len; i++) tick(cur, 1'b0);
      done += len;
    end
    for (int i = 0; i < 12; i++) tick(cur, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
